// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin select arbiter.
package rr_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Binary index to one-hot requester vector.
    function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] s);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    // One-hot requester vector back to its binary index (0 when empty).
    function automatic logic [SEL_W-1:0] encode4(input logic [N_REQ-1:0] g);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (g[i]) r = i[SEL_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating priority encoder: first set candidate at ptr, ptr+1, ptr+2, ptr+3.
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] cand_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic             found_o,
    output logic [SEL_W-1:0] idx_o
);

    logic [SEL_W-1:0] j;

    // Scan from the farthest offset down so the nearest hit to ptr wins last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        j       = '0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            j = ptr_i + k[SEL_W-1:0];
            if (cand_i[j]) begin
                found_o = 1'b1;
                idx_o   = j;
            end
        end
    end

endmodule

// File: rtl/rr_sel_arbiter4.sv
// Round-robin arbiter with hold limit, driving a registered 4:1 mux select.
module rr_sel_arbiter4
    import rr_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             gnt_valid_o,
    output logic             hold_expired_o
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hexp_q, hexp_d;

    logic [N_REQ-1:0] others;
    logic [N_REQ-1:0] cand;
    logic             released;
    logic             expiring;
    logic             take;
    logic             found;
    logic [SEL_W-1:0] idx;

    // Release beats expiry; expiry only rotates toward a waiting competitor.
    assign others   = req_i & ~onehot4(sel_q);
    assign released = (state_q == OWN) && !req_i[sel_q];
    assign expiring = (state_q == OWN) && !released && (cnt_q == HOLD_LAST) && (|others);
    assign cand     = expiring ? others : req_i;
    assign take     = found && ((state_q == IDLE) || released || expiring);

    rr_pick4 u_pick (
        .cand_i  (cand),
        .ptr_i   (ptr_q),
        .found_o (found),
        .idx_o   (idx)
    );

    // Next-state: new grant, drop to idle, or keep owner and age the hold count.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        hexp_d  = 1'b0;
        if (take) begin
            state_d = OWN;
            gnt_d   = onehot4(idx);
            sel_d   = idx;
            ptr_d   = idx + SEL_W'(1);
            cnt_d   = '0;
            hexp_d  = expiring;
        end else if (released) begin
            // sel keeps the last owner so the mux stays put while idle
            state_d = IDLE;
            gnt_d   = '0;
        end else if ((state_q == OWN) && (cnt_q != HOLD_LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset drops the grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            hexp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            hexp_q  <= hexp_d;
        end
    end

    assign gnt_o          = gnt_q;
    assign sel_o          = sel_q;
    assign gnt_valid_o    = |gnt_q;
    assign hold_expired_o = hexp_q;

endmodule

// File: tb/tb_rr_sel_arbiter4.sv
// Bench for rr_sel_arbiter4: two instances (HOLD_MAX=8 and HOLD_MAX=1) share req.
module tb_rr_sel_arbiter4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b1111;

    logic [3:0] gnt  [2];
    logic [1:0] sel  [2];
    logic       vld  [2];
    logic       hexp [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rr_sel_arbiter4 #(.HOLD_MAX(8), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .req_i(req),
        .gnt_o(gnt[0]), .sel_o(sel[0]), .gnt_valid_o(vld[0]), .hold_expired_o(hexp[0])
    );

    rr_sel_arbiter4 #(.HOLD_MAX(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .req_i(req),
        .gnt_o(gnt[1]), .sel_o(sel[1]), .gnt_valid_o(vld[1]), .hold_expired_o(hexp[1])
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner = -1 means idle; held = cycles the current owner has already had the path.
    typedef struct packed {
        int own;
        int ptr;
        int held;
        int sel;
        bit exp_p;
    } mst_t;

    mst_t m_st [2];

    function automatic int hold_of(input int k);
        return (k == 0) ? 8 : 1;
    endfunction

    function automatic int pick(input logic [3:0] v, input int p);
        for (int i = 0; i < 4; i++) begin
            if (v[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    function automatic mst_t mstep(input mst_t s, input int hm, input logic [3:0] r);
        mst_t       n;
        logic [3:0] oth;
        int         pk;
        bit         picked;
        n       = s;
        n.exp_p = 1'b0;
        oth     = r;
        picked  = 1'b0;
        pk      = -1;
        if (s.own >= 0) oth[s.own] = 1'b0;
        if (s.own < 0 || !r[s.own]) begin
            pk     = pick(r, s.ptr);
            picked = 1'b1;
        end else if (s.held >= hm && oth != 4'b0) begin
            pk      = pick(oth, s.ptr);
            picked  = 1'b1;
            n.exp_p = 1'b1;
        end
        if (!picked) begin
            n.held = s.held + 1;
        end else begin
            n.own = pk;
            if (pk >= 0) begin
                n.ptr  = (pk + 1) % 4;
                n.held = 1;
                n.sel  = pk;
            end
        end
        return n;
    endfunction

    function automatic mst_t mreset();
        mst_t z;
        z.own = -1; z.ptr = 0; z.held = 0; z.sel = 0; z.exp_p = 1'b0;
        return z;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) m_st[k] <= mreset();
            else     m_st[k] <= mstep(m_st[k], hold_of(k), req);
        end
    end

    // Compare DUT outputs with the model on every falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [3:0] eg;
            eg = (m_st[k].own < 0) ? 4'b0000 : (4'b0001 << m_st[k].own);
            chk($sformatf("model_gnt[%0d]", k),  {4'b0, gnt[k]}, {4'b0, eg});
            chk($sformatf("model_sel[%0d]", k),  {6'b0, sel[k]}, 8'(m_st[k].sel));
            chk($sformatf("model_vld[%0d]", k),  {7'b0, vld[k]}, {7'b0, |eg});
            chk($sformatf("model_hexp[%0d]", k), {7'b0, hexp[k]}, {7'b0, m_st[k].exp_p});
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        m_st[0] = mreset();
        m_st[1] = mreset();

        // 1: reset with all requesting, then first grant to requester 0
        repeat (3) @(negedge clk);
        chk("rst_gnt", {4'b0, gnt[0]}, 8'h00);
        chk("rst_sel", {6'b0, sel[0]}, 8'h00);
        chk("rst_vld", {7'b0, vld[0]}, 8'h00);
        chk("rst_hexp", {7'b0, hexp[0]}, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("first_gnt", {4'b0, gnt[0]}, 8'h01);
        chk("first_sel", {6'b0, sel[0]}, 8'h00);

        // 2: lone requester 2 holds indefinitely, then idles with sel kept
        req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_gnt", {4'b0, gnt[0]}, 8'h04);
            chk("hold_sel", {6'b0, sel[0]}, 8'h02);
            chk("hold_hexp1", {7'b0, hexp[1]}, 8'h00);
        end
        req = 4'b0000;
        @(negedge clk);
        chk("idle_gnt", {4'b0, gnt[0]}, 8'h00);
        chk("idle_sel", {6'b0, sel[0]}, 8'h02);

        // 3: back-to-back release 1 -> 3 -> 0 (wrap)
        req = 4'b0010;
        @(negedge clk);
        chk("b2b_own1", {4'b0, gnt[0]}, 8'h02);
        req = 4'b1010;
        @(negedge clk);
        chk("b2b_keep1", {4'b0, gnt[0]}, 8'h02);
        req = 4'b1000;
        @(negedge clk);
        chk("b2b_gnt3", {4'b0, gnt[0]}, 8'h08);
        chk("b2b_sel3", {6'b0, sel[0]}, 8'h03);
        req = 4'b0001;
        @(negedge clk);
        chk("wrap_gnt0", {4'b0, gnt[0]}, 8'h01);
        chk("wrap_sel0", {6'b0, sel[0]}, 8'h00);

        // 4: hold expiry with two constant requesters after a fresh reset
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0011;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            chk("exp8_gnt", {4'b0, gnt[0]}, ((i / 8) % 2 == 0) ? 8'h01 : 8'h02);
            chk("exp8_hexp", {7'b0, hexp[0]}, (i > 0 && i % 8 == 0) ? 8'h01 : 8'h00);
            chk("exp1_gnt", {4'b0, gnt[1]}, (i % 2 == 0) ? 8'h01 : 8'h02);
            chk("exp1_hexp", {7'b0, hexp[1]}, (i > 0) ? 8'h01 : 8'h00);
        end

        // 5: fairness, each owner releases after 3 cycles and re-requests next cycle
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 15; i++) begin
            logic [3:0] drop;
            @(negedge clk);
            chk("fair_gnt", {4'b0, gnt[0]}, 8'(4'b0001 << ((i / 3) % 4)));
            drop = 4'b0001 << ((i / 3) % 4);
            req  = (i % 3 == 2) ? (4'b1111 & ~drop) : 4'b1111;
        end

        // 6: asynchronous reset between edges while requester 2 owns
        req = 4'b0100;
        @(negedge clk);
        chk("own2_gnt", {4'b0, gnt[0]}, 8'h04);
        #2 rst = 1'b1;
        #1;
        chk("arst_gnt8", {4'b0, gnt[0]}, 8'h00);
        chk("arst_vld8", {7'b0, vld[0]}, 8'h00);
        chk("arst_gnt1", {4'b0, gnt[1]}, 8'h00);
        chk("arst_sel8", {6'b0, sel[0]}, 8'h00);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("regrant_gnt", {4'b0, gnt[0]}, 8'h04);
        chk("regrant_sel", {6'b0, sel[0]}, 8'h02);

        req = 4'b0000;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
